// File: rtl/instr_fetch.sv
// Fetch stage: owns PC and IR, runs one req/gnt + rvalid read per fetch strobe.
// PC writebacks arriving mid-fetch are held and applied when the fetch retires.
module instr_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0040_0000,
   parameter int          MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        fetch_busy,
   output logic        fetch_done,
   output logic        misaligned_err,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t      state;
   logic        pend_v;
   logic [31:0] pend_pc;
   logic [15:0] tmo_cnt;
   logic        ld_v;
   logic [31:0] ld_pc;
   logic        tmo_hit;

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

   // A load in the retiring cycle itself wins over an older pending one.
   always_comb begin
      ld_v    = pc_load | pend_v;
      ld_pc   = pc_load ? pc_next : pend_pc;
      tmo_hit = (MEM_TIMEOUT != 0) &&
                (tmo_cnt == 16'(MEM_TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         instr          <= 32'h0000_0013;
         imem_req       <= 1'b0;
         fetch_busy     <= 1'b0;
         fetch_done     <= 1'b0;
         misaligned_err <= 1'b0;
         timeout_err    <= 1'b0;
         pend_v         <= 1'b0;
         pend_pc        <= '0;
         tmo_cnt        <= '0;
      end else begin
         fetch_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pc_load) begin
                  pc <= {pc_next[31:2], 2'b00};
                  if (|pc_next[1:0])
                     misaligned_err <= 1'b1;
               end
               if (fetch_start) begin
                  state      <= REQ;
                  imem_req   <= 1'b1;
                  fetch_busy <= 1'b1;
               end
            end
            REQ: begin
               if (pc_load) begin
                  pend_v  <= 1'b1;
                  pend_pc <= pc_next;
               end
               if (imem_gnt) begin
                  state    <= RESP;
                  imem_req <= 1'b0;
                  tmo_cnt  <= '0;
               end
            end
            RESP: begin
               if (imem_rvalid || tmo_hit) begin
                  state      <= IDLE;
                  fetch_busy <= 1'b0;
                  pend_v     <= 1'b0;
                  if (imem_rvalid) begin
                     instr      <= imem_rdata;
                     fetch_done <= 1'b1;
                  end else begin
                     timeout_err <= 1'b1;
                  end
                  if (ld_v) begin
                     pc <= {ld_pc[31:2], 2'b00};
                     if (|ld_pc[1:0])
                        misaligned_err <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
                  if (pc_load) begin
                     pend_v  <= 1'b1;
                     pend_pc <= pc_next;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               imem_req   <= 1'b0;
               fetch_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage for the RV32I multicycle core, directly upstream of the control unit FSM and decoder.
- Holds the PC and instruction register (IR).
- On a fetch strobe (issued while the control unit is in FETCH_S1), runs a req/gnt + rvalid read on the instruction-memory port and latches the returned word into IR.
- IR feeds opcode/mnemonic decode.
- Accepts the next-PC value from the writeback path.

Parameters:
RESET_PC, 32'h0040_0000, PC value after reset (text-segment base).
MEM_TIMEOUT, 16, max cycles waiting for rvalid before error abort; 0 disables timeout.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-low reset
fetch_start  input  1  one-cycle strobe from control unit: begin fetch at current PC
pc_load  input  1  load pc_next into PC (writeback of branch/jump/PC+4)
pc_next  input  32  next PC value
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word address of request (= PC)
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  imem_rdata valid this cycle
imem_rdata  input  32  returned instruction word
pc  output  32  current PC
pc_plus4  output  32  pc + 4, combinational, modulo 2^32
instr  output  32  instruction register
fetch_busy  output  1  high in REQ or RESP state
fetch_done  output  1  one-cycle pulse: IR updated with the new instruction
misaligned_err  output  1  sticky: pc_next with [1:0] != 0 was loaded
timeout_err  output  1  sticky: memory response timed out

Behaviour:
- Reset (rst low, asynchronous):
  - pc = RESET_PC, instr = 32'h0000_0013 (NOP).
  - FSM = IDLE.
  - imem_req, fetch_busy, fetch_done, misaligned_err, timeout_err = 0.
  - Pending-load register cleared.
- States and transitions:
  - IDLE -> REQ on fetch_start.
  - REQ: imem_req=1 and imem_addr=pc, both held stable until imem_gnt. REQ -> RESP on imem_gnt.
  - RESP: imem_req=0. On imem_rvalid: instr <= imem_rdata, fetch_done pulses in the next cycle, -> IDLE.
- Latency: fetch_start at cycle 0 -> imem_req high at cycle 1 (registered). With gnt at cycle 1 and rvalid at cycle 2, instr updates at the cycle-3 edge and fetch_done is high during cycle 3. Minimum start-to-done is 3 cycles.
- rvalid while in REQ or IDLE is ignored.
- fetch_start while busy is ignored. No queuing.
- pc_load in IDLE: pc <= {pc_next[31:2], 2'b00} at the next edge.
- pc_load and fetch_start in the same IDLE cycle:
  - PC updates.
  - The request uses the new PC; imem_addr in REQ already shows the loaded value.
- pc_load while busy:
  - Value captured in the pending register; the last load wins if several arrive.
  - Applied to pc in the cycle fetch_done is high.
  - The in-flight request address never changes.
- Misalignment: pc_next[1:0] != 0 on an accepted load (direct or pending) sets misaligned_err. The low bits are cleared.
- Timeout (MEM_TIMEOUT > 0):
  - Counter counts cycles in RESP without rvalid.
  - On reaching MEM_TIMEOUT: -> IDLE, timeout_err set, instr unchanged, no fetch_done.
  - Pending load is still applied.
- PC arithmetic: pc_plus4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset mid-fetch: immediate return to IDLE. Outstanding rvalid after reset release is ignored.
- Sticky errors clear only on reset.

Test Plan:
- Reset release, fetch_start, gnt same cycle as req, rvalid 1 cycle later with rdata=32'h00500093 -> imem_addr=32'h0040_0000, instr=32'h00500093 with fetch_done at cycle 3, pc unchanged.
- gnt delayed 3 cycles -> imem_req and imem_addr=32'h0040_0000 stable for 4 cycles; single fetch_done.
- pc_load pc_next=32'h0040_0100 during RESP, rvalid later -> imem_addr unchanged during fetch; pc=32'h0040_0100 after fetch_done.
- pc_load pc_next=32'h0040_0006 in IDLE -> pc=32'h0040_0004, misaligned_err=1 and stays 1.
- MEM_TIMEOUT=16, gnt but no rvalid -> after 16 RESP cycles: timeout_err=1, FSM IDLE, instr keeps previous value, no fetch_done; late rvalid ignored.
- rst low asserted mid-RESP -> outputs at reset values immediately; a later fetch_start fetches from 32'h0040_0000.
